// File: rtl/dma_bus_master_pkg.sv
// Shared state encoding, default timing constants and counter sizing
// for the C64 expansion-port DMA bus master.
package dma_bus_master_pkg;

   localparam int HALT_CYCLES_DEF   = 3;
   localparam int LINGER_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_READY,
      S_CYCLE,
      S_LINGER
   } state_e;

   // Bits needed to hold 0..n inclusive, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dma_bus_master_sync_edge.sv
// Two-flop synchronizer for a raw C64 signal with registered
// single-clk rise and fall pulses.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic r_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/dma_bus_master.sv
// C64 expansion-port DMA master: halts the CPU, runs one bus cycle per
// toggle request and lingers briefly so back-to-back requests skip the halt.
module dma_bus_master
   import dma_bus_master_pkg::*;
#(
   parameter int HALT_CYCLES   = HALT_CYCLES_DEF,
   parameter int LINGER_CYCLES = LINGER_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] dma_a,
   input  logic [7:0]  dma_d,
   input  logic        dma_rw,
   input  logic        dma_req,
   output logic        dma_ack,
   output logic [7:0]  dma_q,
   input  logic        phi2_in,
   input  logic        ba_in,
   input  logic [7:0]  bus_d_in,
   output logic        phi2tick,
   output logic        dma_n,
   output logic [15:0] bus_a,
   output logic        bus_a_oe,
   output logic        bus_rw,
   output logic [7:0]  bus_d,
   output logic        bus_d_oe
);

   localparam int HW = cnt_w(HALT_CYCLES);
   localparam int LW = cnt_w(LINGER_CYCLES);
   localparam logic [HW-1:0] HALT_MAX   = HW'(HALT_CYCLES);
   localparam logic [LW-1:0] LINGER_MAX = LW'(LINGER_CYCLES);

   state_e        r_state;
   logic [HW-1:0] r_hcnt;
   logic [LW-1:0] r_lcnt;
   logic [15:0]   r_a;
   logic [7:0]    r_d;
   logic          r_rw;
   logic          r_ack;
   logic [7:0]    r_q;
   logic          r_dma_n;
   logic [15:0]   r_bus_a;
   logic          r_bus_a_oe;
   logic          r_bus_rw;
   logic [7:0]    r_bus_d;
   logic          r_bus_d_oe;

   logic w_phi2_sync;
   logic w_rise;
   logic w_fall;
   logic w_ba_sync;
   logic w_ba_rise;
   logic w_ba_fall;
   logic w_pending;
   logic w_unused;

   sync_edge u_phi2 (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_async (phi2_in),
      .o_sync  (w_phi2_sync),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   sync_edge u_ba (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_async (ba_in),
      .o_sync  (w_ba_sync),
      .o_rise  (w_ba_rise),
      .o_fall  (w_ba_fall)
   );

   assign w_unused  = ^{w_phi2_sync, w_ba_rise, w_ba_fall};
   assign w_pending = dma_req ^ r_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_hcnt     <= '0;
         r_lcnt     <= '0;
         r_a        <= '0;
         r_d        <= '0;
         r_rw       <= 1'b0;
         r_ack      <= 1'b0;
         r_q        <= '0;
         r_dma_n    <= 1'b1;
         r_bus_a    <= '0;
         r_bus_a_oe <= 1'b0;
         r_bus_rw   <= 1'b1;
         r_bus_d    <= '0;
         r_bus_d_oe <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_pending) begin
                  r_a     <= dma_a;
                  r_d     <= dma_d;
                  r_rw    <= dma_rw;
                  r_hcnt  <= '0;
                  r_state <= S_HALT;
               end
            end
            S_HALT: begin
               // DMA may only drop while phi2 is low.
               if (r_dma_n) begin
                  if (w_fall) r_dma_n <= 1'b0;
               end else if (r_hcnt >= HALT_MAX) begin
                  r_state <= S_READY;
               end else if (w_rise) begin
                  r_hcnt <= r_hcnt + HW'(1);
               end
            end
            S_READY: begin
               if (w_rise && w_ba_sync) begin
                  r_bus_a    <= r_a;
                  r_bus_a_oe <= 1'b1;
                  r_bus_rw   <= ~r_rw;
                  r_bus_d    <= r_d;
                  r_bus_d_oe <= r_rw;
                  r_state    <= S_CYCLE;
               end
            end
            S_CYCLE: begin
               if (w_fall) begin
                  if (!r_rw) r_q <= bus_d_in;
                  r_ack      <= ~r_ack;
                  r_bus_a_oe <= 1'b0;
                  r_bus_d_oe <= 1'b0;
                  r_bus_rw   <= 1'b1;
                  r_lcnt     <= '0;
                  r_state    <= S_LINGER;
               end
            end
            S_LINGER: begin
               // A new request beats the release on the same fall.
               if (w_pending) begin
                  r_a     <= dma_a;
                  r_d     <= dma_d;
                  r_rw    <= dma_rw;
                  r_state <= S_READY;
               end else if (r_lcnt >= LINGER_MAX) begin
                  if (w_fall) begin
                     r_dma_n <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else if (w_rise) begin
                  r_lcnt <= r_lcnt + LW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dma_ack  = r_ack;
   assign dma_q    = r_q;
   assign phi2tick = w_rise;
   assign dma_n    = r_dma_n;
   assign bus_a    = r_bus_a;
   assign bus_a_oe = r_bus_a_oe;
   assign bus_rw   = r_bus_rw;
   assign bus_d    = r_bus_d;
   assign bus_d_oe = r_bus_d_oe;

endmodule

// File: tb/tb_dma_bus_master.sv
// Randomized self-checking bench for dma_bus_master against a
// phi2-cycle-level model of the request/halt/cycle/linger protocol.
module tb_dma_bus_master;

   localparam int HALT     = 3;
   localparam int LING     = 2;
   localparam int HALF_CLK = 8;
   localparam int TMO      = 3000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] dma_a;
   logic [7:0]  dma_d;
   logic        dma_rw;
   logic        dma_req;
   logic        dma_ack;
   logic [7:0]  dma_q;
   logic        phi2_in;
   logic        ba_in;
   logic [7:0]  bus_d_in;
   logic        phi2tick;
   logic        dma_n;
   logic [15:0] bus_a;
   logic        bus_a_oe;
   logic        bus_rw;
   logic [7:0]  bus_d;
   logic        bus_d_oe;

   int n_chk  = 0;
   int n_fail = 0;
   int phi_rises = 0;
   int cyc_cnt   = 0;
   int doe_clks  = 0;
   int ack_tog   = 0;
   int dman_rise = 0;
   int tick_cnt  = 0;
   logic prev_aoe  = 1'b0;
   logic prev_ack  = 1'b0;
   logic prev_dman = 1'b1;
   logic [7:0] exp_q = 8'h00;

   dma_bus_master #(
      .HALT_CYCLES   (HALT),
      .LINGER_CYCLES (LING)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .dma_a    (dma_a),
      .dma_d    (dma_d),
      .dma_rw   (dma_rw),
      .dma_req  (dma_req),
      .dma_ack  (dma_ack),
      .dma_q    (dma_q),
      .phi2_in  (phi2_in),
      .ba_in    (ba_in),
      .bus_d_in (bus_d_in),
      .phi2tick (phi2tick),
      .dma_n    (dma_n),
      .bus_a    (bus_a),
      .bus_a_oe (bus_a_oe),
      .bus_rw   (bus_rw),
      .bus_d    (bus_d),
      .bus_d_oe (bus_d_oe)
   );

   always #5 clk = ~clk;

   // Free-running phi2, deliberately off the clk grid.
   initial begin
      phi2_in = 1'b0;
      #3;
      forever begin
         #80 phi2_in = 1'b1;
         phi_rises++;
         #80 phi2_in = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (bus_d_oe) doe_clks++;
      if (phi2tick) tick_cnt++;
      if (bus_a_oe && !prev_aoe) cyc_cnt++;
      if (reset_n && dma_ack != prev_ack) ack_tog++;
      if (dma_n && !prev_dman) dman_rise++;
      prev_aoe  = bus_a_oe;
      prev_ack  = dma_ack;
      prev_dman = dma_n;
   end

   task automatic issue(input logic [15:0] a, input logic [7:0] d,
                        input logic rw);
      @(negedge clk);
      dma_a   = a;
      dma_d   = d;
      dma_rw  = rw;
      dma_req = ~dma_req;
   endtask

   task automatic wait_aoe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         @(negedge clk);
         if (bus_a_oe) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ack(input logic prev, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         @(negedge clk);
         if (dma_ack !== prev) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_dman(input logic v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         @(negedge clk);
         if (dma_n === v) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [37:0] got;
      reset_n  = 1'b0;
      dma_a    = '0;
      dma_d    = '0;
      dma_rw   = 1'b0;
      dma_req  = 1'b0;
      ba_in    = 1'b1;
      bus_d_in = '0;
      repeat (4) @(negedge clk);
      got = {dma_ack, dma_q, dma_n, bus_a_oe, bus_d_oe, bus_rw,
             bus_a, bus_d, phi2tick};
      n_chk++;
      if (got !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1,
                   16'h0000, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want %h", got,
                  {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1,
                   16'h0000, 8'h00, 1'b0});
      end
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      n_chk++;
      if ({dma_n, bus_a_oe} !== 2'b10) begin
         n_fail++;
         $display("FAIL idle_quiet: dma_n,aoe got %b want 10",
                  {dma_n, bus_a_oe});
      end
   endtask

   task automatic test_read();
      bit ok;
      int p0, p1, a0, t1;
      logic pa;
      bus_d_in = 8'h0E;
      ba_in    = 1'b1;
      pa = dma_ack;
      issue(16'hD020, 8'hAA, 1'b0);
      wait_dman(1'b0, ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL read_dman_low: got timeout want dma_n=0");
      end
      n_chk++;
      if (phi2_in !== 1'b0) begin
         n_fail++;
         $display("FAIL read_dman_phase: phi2 got %b want 0", phi2_in);
      end
      p0 = phi_rises;
      a0 = ack_tog;
      wait_aoe(ok);
      n_chk++;
      if (phi_rises - p0 != HALT + 1) begin
         n_fail++;
         $display("FAIL read_halt_len: got %0d want %0d phi2",
                  phi_rises - p0, HALT + 1);
      end
      n_chk++;
      if ({bus_a, bus_rw, bus_d_oe} !== {16'hD020, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL read_bus: got a=%h rw=%b doe=%b want D020 1 0",
                  bus_a, bus_rw, bus_d_oe);
      end
      wait_ack(pa, ok);
      exp_q = 8'h0E;
      n_chk++;
      if (!ok || dma_q !== exp_q) begin
         n_fail++;
         $display("FAIL read_q: got %h want %h", dma_q, exp_q);
      end
      p1 = phi_rises;
      t1 = tick_cnt;
      wait_dman(1'b1, ok);
      n_chk++;
      if (!ok || phi_rises - p1 != LING) begin
         n_fail++;
         $display("FAIL linger_len: got %0d want %0d phi2",
                  phi_rises - p1, LING);
      end
      n_chk++;
      if (tick_cnt - t1 != phi_rises - p1) begin
         n_fail++;
         $display("FAIL phi2tick_count: got %0d want %0d",
                  tick_cnt - t1, phi_rises - p1);
      end
      n_chk++;
      if (ack_tog - a0 != 1) begin
         n_fail++;
         $display("FAIL read_ack_count: got %0d want 1", ack_tog - a0);
      end
   endtask

   task automatic test_write();
      bit ok;
      int d0;
      logic pa;
      bus_d_in = 8'($urandom);
      d0 = doe_clks;
      pa = dma_ack;
      issue(16'h0400, 8'h41, 1'b1);
      wait_aoe(ok);
      n_chk++;
      if (!ok || {bus_a, bus_rw, bus_d_oe, bus_d} !==
          {16'h0400, 1'b0, 1'b1, 8'h41}) begin
         n_fail++;
         $display("FAIL write_bus: got a=%h rw=%b doe=%b d=%h want 0400 0 1 41",
                  bus_a, bus_rw, bus_d_oe, bus_d);
      end
      wait_ack(pa, ok);
      repeat (2) @(negedge clk);
      n_chk++;
      if (!ok || dma_q !== exp_q) begin
         n_fail++;
         $display("FAIL write_q_kept: got %h want %h", dma_q, exp_q);
      end
      n_chk++;
      if (doe_clks - d0 != HALF_CLK) begin
         n_fail++;
         $display("FAIL write_doe_len: got %0d want %0d clk",
                  doe_clks - d0, HALF_CLK);
      end
      wait_dman(1'b1, ok);
   endtask

   task automatic test_back_to_back();
      bit ok;
      int r0, n0;
      logic pa;
      logic [15:0] a2;
      logic rw1, rw2;
      rw1 = 1'($urandom);
      rw2 = 1'($urandom);
      a2  = 16'($urandom);
      bus_d_in = 8'($urandom);
      pa = dma_ack;
      issue(16'($urandom), 8'($urandom), rw1);
      wait_ack(pa, ok);
      if (!rw1) exp_q = bus_d_in;
      r0 = phi_rises;
      n0 = dman_rise;
      repeat ($urandom_range(0, 14)) @(negedge clk);
      bus_d_in = 8'($urandom);
      pa = dma_ack;
      issue(a2, 8'($urandom), rw2);
      wait_aoe(ok);
      n_chk++;
      if (!ok || phi_rises - r0 > 2) begin
         n_fail++;
         $display("FAIL b2b_no_halt: got %0d want <=2 phi2", phi_rises - r0);
      end
      n_chk++;
      if ({bus_a, bus_rw} !== {a2, ~rw2}) begin
         n_fail++;
         $display("FAIL b2b_bus: got %h/%b want %h/%b",
                  bus_a, bus_rw, a2, ~rw2);
      end
      wait_ack(pa, ok);
      if (!rw2) exp_q = bus_d_in;
      n_chk++;
      if (!ok || dma_q !== exp_q) begin
         n_fail++;
         $display("FAIL b2b_q: got %h want %h", dma_q, exp_q);
      end
      n_chk++;
      if (dman_rise - n0 != 0) begin
         n_fail++;
         $display("FAIL b2b_dman: got %0d releases want 0", dman_rise - n0);
      end
      wait_dman(1'b1, ok);
   endtask

   task automatic test_random();
      bit ok;
      int a0;
      logic pa;
      logic [15:0] a;
      logic [7:0] d;
      logic rw;
      for (int k = 0; k < 6; k++) begin
         a  = 16'($urandom);
         d  = 8'($urandom);
         rw = 1'($urandom);
         bus_d_in = 8'($urandom);
         a0 = ack_tog;
         pa = dma_ack;
         issue(a, d, rw);
         wait_aoe(ok);
         n_chk++;
         if (!ok || {bus_a, bus_rw, bus_d_oe} !== {a, ~rw, rw} ||
             (rw && bus_d !== d)) begin
            n_fail++;
            $display("FAIL rand_bus[%0d]: got %h/%b/%b/%h want %h/%b/%b/%h",
                     k, bus_a, bus_rw, bus_d_oe, bus_d, a, ~rw, rw, d);
         end
         wait_ack(pa, ok);
         if (!rw) exp_q = bus_d_in;
         repeat (2) @(negedge clk);
         n_chk++;
         if (!ok || dma_q !== exp_q || ack_tog - a0 != 1) begin
            n_fail++;
            $display("FAIL rand_ack[%0d]: q=%h acks=%0d want q=%h acks=1",
                     k, dma_q, ack_tog - a0, exp_q);
         end
         if ($urandom_range(0, 1) == 0) wait_dman(1'b1, ok);
      end
      wait_dman(1'b1, ok);
   endtask

   task automatic test_ba_stall();
      bit ok;
      int p0, p1, c0, a0;
      logic pa;
      ba_in    = 1'b1;
      bus_d_in = 8'($urandom);
      pa = dma_ack;
      issue(16'($urandom), 8'($urandom), 1'b0);
      wait_dman(1'b0, ok);
      ba_in = 1'b0;
      p0 = phi_rises;
      c0 = cyc_cnt;
      a0 = ack_tog;
      for (int i = 0; i < 50 * 2 * HALF_CLK; i++) begin
         @(negedge clk);
         if (phi_rises - p0 >= HALT + 40) break;
      end
      for (int i = 0; i < 4 * HALF_CLK; i++) begin
         @(negedge clk);
         if (phi2_in == 1'b0) break;
      end
      n_chk++;
      if (cyc_cnt != c0 || ack_tog != a0 || bus_a_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL ba_stall: cycles=%0d acks=%0d want 0 0",
                  cyc_cnt - c0, ack_tog - a0);
      end
      ba_in = 1'b1;
      p1 = phi_rises;
      wait_aoe(ok);
      n_chk++;
      if (!ok || phi_rises - p1 != 1) begin
         n_fail++;
         $display("FAIL ba_resume: got %0d want 1 phi2", phi_rises - p1);
      end
      wait_ack(pa, ok);
      exp_q = bus_d_in;
      n_chk++;
      if (!ok || dma_q !== exp_q) begin
         n_fail++;
         $display("FAIL ba_q: got %h want %h", dma_q, exp_q);
      end
      wait_dman(1'b1, ok);
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic pa;
      issue(16'($urandom), 8'($urandom), 1'b1);
      wait_aoe(ok);
      #2 reset_n = 1'b0;
      #1;
      n_chk++;
      if ({bus_a_oe, bus_d_oe, dma_n, dma_ack, dma_q} !==
          {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_mid: aoe=%b doe=%b dma_n=%b ack=%b q=%h want 0 0 1 0 00",
                  bus_a_oe, bus_d_oe, dma_n, dma_ack, dma_q);
      end
      exp_q = 8'h00;
      @(negedge clk);
      dma_req = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      bus_d_in = 8'($urandom);
      pa = dma_ack;
      issue(16'($urandom), 8'($urandom), 1'b0);
      wait_ack(pa, ok);
      exp_q = bus_d_in;
      n_chk++;
      if (!ok || dma_q !== exp_q) begin
         n_fail++;
         $display("FAIL reset_recover: got %h want %h", dma_q, exp_q);
      end
      wait_dman(1'b1, ok);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_random();
      test_ba_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_bus_master.md
DMA_BUS_MASTER -- requirements
Module: dma_bus_master

Interface
REQ-001 Parameter HALT_CYCLES, default 3: phi2 cycles waited after asserting DMA before the first bus cycle (CPU write-cycle drain).
REQ-002 Parameter LINGER_CYCLES, default 2: phi2 cycles DMA stays asserted with no pending request before release.
REQ-003 clk  in  1  system clock; one clock domain; reset is asynchronous and active-low.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 dma_a  in  16  C64 address for the requested cycle.
REQ-006 dma_d  in  8  write data.
REQ-007 dma_rw  in  1  1 = write to C64, 0 = read.
REQ-008 dma_req  in  1  toggle request; a request is pending when dma_req != dma_ack.
REQ-009 dma_ack  out  1  toggle acknowledge.
REQ-010 dma_q  out  8  read data, valid from the dma_ack toggle until the next request completes.
REQ-011 phi2_in  in  1  raw C64 phi2, asynchronous.
REQ-012 ba_in  in  1  raw VIC BA, asynchronous; 0 = bus stolen.
REQ-013 bus_d_in  in  8  C64 data bus input.
REQ-014 phi2tick  out  1  one-clk pulse per synchronized phi2 rising edge.
REQ-015 dma_n  out  1  expansion-port DMA line, active low.
REQ-016 bus_a  out  16  address output.
REQ-017 bus_a_oe  out  1  address/RW drive enable.
REQ-018 bus_rw  out  1  C64 R/W, 1 = read (inverse of dma_rw).
REQ-019 bus_d  out  8  data output.
REQ-020 bus_d_oe  out  1  data drive enable.

Function
REQ-021 phi2_in and ba_in SHALL pass through a 2-flop synchronizer; edges are detected on the synchronized phi2 (rise = phi2tick, fall = fall_tick).
REQ-022 FSM states SHALL be IDLE, HALT, READY, CYCLE, LINGER.
REQ-023 IDLE: on pending request, latch dma_a/dma_d/dma_rw, clear the halt counter, and go to HALT; dma_n drops on the next fall_tick (phi2 low phase only).
REQ-024 HALT: count phi2tick while dma_n = 0; after HALT_CYCLES counts, go to READY.
REQ-025 READY: on phi2tick with synchronized BA = 1, go to CYCLE; with BA = 0, skip that phi2 cycle with no bus drive.
REQ-026 CYCLE: bus_a_oe = 1, bus_a = latched address, bus_rw = ~latched rw; bus_d_oe = 1 only for writes.
REQ-027 CYCLE: at fall_tick, capture bus_d_in into dma_q (reads only), toggle dma_ack, deassert all OEs in the same clk, and go to LINGER.
REQ-028 LINGER: a pending request latches its operands and goes to READY with no re-halt; after LINGER_CYCLES phi2tick with no request, raise dma_n at fall_tick and go to IDLE.
REQ-029 A request arriving while busy SHALL NOT be latched before the current dma_ack toggle; requests are strictly serialized.
REQ-030 A request seen in the same clk as the LINGER expiry fall_tick SHALL win: dma_n stays low.
REQ-031 Latency: minimum of one phi2 cycle from READY to ack; exactly one ack toggle per request.
REQ-032 Counters SHALL be wide enough for their parameter and saturate, never wrap.
REQ-033 Outputs SHALL be registered.

Reset
REQ-034 Reset values: dma_ack = 0, dma_q = 0x00, dma_n = 1, bus_a_oe = 0, bus_d_oe = 0, bus_rw = 1, bus_a = 0x0000, bus_d = 0x00, phi2tick = 0, state IDLE, counters 0.
REQ-035 Reset mid-cycle SHALL immediately release the bus and DMA; a lost request is not acknowledged, and the requester resynchronizes its req to dma_ack.

Structure
REQ-036 A shared package SHALL hold the state encoding and the default HALT_CYCLES and LINGER_CYCLES constants.
REQ-037 One sub-module, sync_edge (2-flop synchronizer plus rise/fall pulse), SHALL be instantiated for phi2 and for BA.

Verification
REQ-038 Read: req toggle, a = 0xD020, bus_d_in = 0x0E -> dma_n low at the next fall; first bus cycle after 3 phi2; dma_q = 0x0E; one ack toggle.
REQ-039 Write: a = 0x0400, d = 0x41 -> bus_rw = 0 and bus_d_oe = 1 for exactly one phi2-high phase; bus_d = 0x41.
REQ-040 Back-to-back: second req issued within 1 phi2 of the first ack -> no re-halt; dma_n stays low throughout.
REQ-041 BA low for 40 phi2 cycles while in READY -> no bus drive, no ack; the cycle completes on the first phi2 with BA = 1.
REQ-042 Reset_n pulsed during CYCLE -> all OEs 0 and dma_n = 1 asynchronously; dma_ack = 0.
REQ-043 Idle -> dma_n returns high exactly LINGER_CYCLES = 2 phi2 after the last ack.
